// File: rtl/nv_nvdla_pdp_rdma_eg.sv
// PDP RDMA egress: tags each raw read beat with its width position and
// line/surface/cube/split end flags, and forwards it to the PDP core through
// a single output register with valid/ready handshaking.
module nv_nvdla_pdp_rdma_eg (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        reg2dp_op_en,
  input  logic [12:0] reg2dp_cube_in_width,
  input  logic [12:0] reg2dp_cube_in_height,
  input  logic [12:0] reg2dp_surf_num,
  input  logic [7:0]  reg2dp_split_num,
  input  logic [31:0] rd_data_pd,
  input  logic        rd_data_valid,
  output logic        rd_data_ready,
  output logic [45:0] pdp_rdma2dp_pd,
  output logic        pdp_rdma2dp_valid,
  input  logic        pdp_rdma2dp_ready,
  output logic        eg_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t      state_q, state_d;
  logic        op_en_d1_q, op_en_d1_d;
  logic [12:0] width_q, width_d, height_q, height_d, surf_num_q, surf_num_d;
  logic [7:0]  split_num_q, split_num_d;
  logic [12:0] w_q, w_d, h_q, h_d, surf_q, surf_d;
  logic [7:0]  split_q, split_d;
  logic [45:0] pd_q, pd_d;
  logic        valid_q, valid_d;
  logic        eg_done_q, eg_done_d;

  logic        op_en_rise, rd_ready, load, accept;
  logic        line_end, surf_end, cube_end, split_end;

  // Next-state logic: FSM, counters, output register and done pulse.
  always_comb begin
    state_d     = state_q;
    op_en_d1_d  = reg2dp_op_en;
    width_d     = width_q;
    height_d    = height_q;
    surf_num_d  = surf_num_q;
    split_num_d = split_num_q;
    w_d         = w_q;
    h_d         = h_q;
    surf_d      = surf_q;
    split_d     = split_q;
    pd_d        = pd_q;
    valid_d     = valid_q;
    eg_done_d   = 1'b0;

    op_en_rise = reg2dp_op_en & ~op_en_d1_q;
    rd_ready   = (state_q == ST_RUN) & (~valid_q | pdp_rdma2dp_ready);
    load       = rd_data_valid & rd_ready;
    accept     = valid_q & pdp_rdma2dp_ready;

    // Flags reflect the position of the beat being loaded (pre-increment).
    line_end  = (w_q == width_q);
    surf_end  = line_end & (h_q == height_q);
    cube_end  = surf_end & (surf_q == surf_num_q);
    split_end = cube_end & (split_q == split_num_q);

    case (state_q)
      ST_IDLE: begin
        if (op_en_rise) begin
          state_d     = ST_RUN;
          width_d     = reg2dp_cube_in_width;
          height_d    = reg2dp_cube_in_height;
          surf_num_d  = reg2dp_surf_num;
          split_num_d = reg2dp_split_num;
          w_d         = 13'd0;
          h_d         = 13'd0;
          surf_d      = 13'd0;
          split_d     = 8'd0;
        end
      end
      ST_RUN: begin
        if (load && split_end) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (accept) begin
          state_d   = ST_IDLE;
          eg_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      pd_d    = {cube_end, 1'b0, surf_end, line_end, split_end, w_q[8:0], rd_data_pd};
      valid_d = 1'b1;
      // Nested counters: each wraps when it hits its limit and the inner one wraps.
      w_d = line_end ? 13'd0 : w_q + 13'd1;
      if (line_end) begin
        h_d = surf_end ? 13'd0 : h_q + 13'd1;
      end
      if (surf_end) begin
        surf_d = cube_end ? 13'd0 : surf_q + 13'd1;
      end
      if (cube_end) begin
        split_d = split_end ? 8'd0 : split_q + 8'd1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q     <= ST_IDLE;
      op_en_d1_q  <= 1'b0;
      width_q     <= 13'd0;
      height_q    <= 13'd0;
      surf_num_q  <= 13'd0;
      split_num_q <= 8'd0;
      w_q         <= 13'd0;
      h_q         <= 13'd0;
      surf_q      <= 13'd0;
      split_q     <= 8'd0;
      pd_q        <= 46'd0;
      valid_q     <= 1'b0;
      eg_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_en_d1_q  <= op_en_d1_d;
      width_q     <= width_d;
      height_q    <= height_d;
      surf_num_q  <= surf_num_d;
      split_num_q <= split_num_d;
      w_q         <= w_d;
      h_q         <= h_d;
      surf_q      <= surf_d;
      split_q     <= split_d;
      pd_q        <= pd_d;
      valid_q     <= valid_d;
      eg_done_q   <= eg_done_d;
    end
  end

  assign rd_data_ready     = rd_ready;
  assign pdp_rdma2dp_pd    = pd_q;
  assign pdp_rdma2dp_valid = valid_q;
  assign eg_done           = eg_done_q;

endmodule

// File: tb/tb_nv_nvdla_pdp_rdma_eg.sv
// Directed bench for the PDP RDMA egress block.
module tb_nv_nvdla_pdp_rdma_eg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_en = 1'b0;
  logic [12:0] cfg_w = '0, cfg_h = '0, cfg_s = '0;
  logic [7:0]  cfg_sp = '0;
  logic [31:0] rd_pd = '0;
  logic        rd_valid = 1'b0;
  logic        rd_ready;
  logic [45:0] pd;
  logic        pd_valid;
  logic        pd_ready = 1'b1;
  logic        done_pulse;

  int checks = 0;
  int errors = 0;
  int data_next = 32'h100;
  int base;
  logic [45:0] pkts[$];

  nv_nvdla_pdp_rdma_eg dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rst        (rst),
    .reg2dp_op_en          (op_en),
    .reg2dp_cube_in_width  (cfg_w),
    .reg2dp_cube_in_height (cfg_h),
    .reg2dp_surf_num       (cfg_s),
    .reg2dp_split_num      (cfg_sp),
    .rd_data_pd            (rd_pd),
    .rd_data_valid         (rd_valid),
    .rd_data_ready         (rd_ready),
    .pdp_rdma2dp_pd        (pd),
    .pdp_rdma2dp_valid     (pd_valid),
    .pdp_rdma2dp_ready     (pd_ready),
    .eg_done               (done_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [45:0] pkt(input int i);
    if (i < pkts.size()) return pkts[i];
    return 46'h0;
  endfunction

  // Feeds an always-valid incrementing data stream, collects accepted packets,
  // and checks handshake timing, stall stability and the done pulse.
  task automatic run_layer(input bit do_pulse, input int mid_pulse, input bit toggle_rdy,
                           input int exp_n, input string tag);
    int cyc, last_acc, eg_cyc, first_ld, first_vld;
    logic [45:0] held;
    bit stalled, finished;
    pkts.delete();
    base = data_next;
    if (do_pulse) begin
      op_en = 1'b1;
      tick();
      op_en = 1'b0;
    end
    rd_valid = 1'b1;
    cyc = 0; last_acc = -100; eg_cyc = -1; first_ld = -1; first_vld = -1;
    stalled = 0; finished = 0; held = '0;
    while (!finished && cyc < 3000) begin
      pd_ready = toggle_rdy ? (cyc % 2 == 0) : 1'b1;
      rd_pd    = data_next;
      op_en    = (cyc == mid_pulse);
      #1;
      if (pd_valid) begin
        if (first_vld < 0) first_vld = cyc;
        if (stalled) chk({tag, "_stable"}, pd, held);
        if (pd_ready) begin
          pkts.push_back(pd);
          last_acc = cyc;
          stalled = 0;
        end else begin
          stalled = 1;
          held = pd;
        end
      end
      if (rd_ready) begin
        if (first_ld < 0) first_ld = cyc;
        data_next++;
      end
      if (done_pulse) begin
        eg_cyc = cyc;
        finished = 1;
      end
      tick();
      cyc++;
    end
    op_en = 1'b0;
    pd_ready = 1'b1;
    chk({tag, "_finished"}, finished, 1);
    chk({tag, "_count"}, pkts.size(), exp_n);
    chk({tag, "_latency"}, first_vld - first_ld, 1);
    chk({tag, "_eg_gap"}, eg_cyc - last_acc, 1);
    for (int i = 0; i < exp_n; i++) chk({tag, "_data"}, pkt(i)[31:0], base + i);
    // After done: a single-cycle pulse, and the block stays idle.
    for (int i = 0; i < 4; i++) begin
      #1;
      chk({tag, "_post_done"}, done_pulse, 0);
      chk({tag, "_post_ready"}, rd_ready, 0);
      tick();
    end
    rd_valid = 1'b0;
  endtask

  initial begin
    int n_end;
    logic [4:0] exp_a [8];
    exp_a = '{5'b00000, 5'b00000, 5'b00000, 5'b00010,
              5'b00000, 5'b00000, 5'b00000, 5'b10111};

    // Reset state, with input valid held to expose a stray ready.
    rd_valid = 1'b1;
    tick(); tick();
    chk("rst_valid", pd_valid, 0);
    chk("rst_pd", pd, 46'h0);
    chk("rst_ready", rd_ready, 0);
    chk("rst_done", done_pulse, 0);
    rst = 1'b0;
    rd_valid = 1'b0;
    tick(); tick();
    chk("idle_ready", rd_ready, 0);

    // 4x2 single-surface layer with ready held high.
    cfg_w = 13'd3; cfg_h = 13'd1; cfg_s = 13'd0; cfg_sp = 8'd0;
    run_layer(1, -1, 0, 8, "A");
    for (int i = 0; i < 8; i++) begin
      chk("A_flags", pkt(i)[45:41], exp_a[i]);
      chk("A_wfield", pkt(i)[40:32], i % 4);
    end

    // Two splits with unit dimensions: only the second is the layer end.
    cfg_w = 13'd0; cfg_h = 13'd0; cfg_s = 13'd0; cfg_sp = 8'd1;
    run_layer(1, -1, 0, 2, "B");
    chk("B_flags0", pkt(0)[45:41], 5'b10110);
    chk("B_flags1", pkt(1)[45:41], 5'b10111);
    n_end = 0;
    for (int i = 0; i < pkts.size(); i++) if (pkts[i][45] && pkts[i][41]) n_end++;
    chk("B_layer_ends", n_end, 1);

    // Ready toggling 1,0,1,0 over a 3x2x2 cube.
    cfg_w = 13'd2; cfg_h = 13'd1; cfg_s = 13'd1; cfg_sp = 8'd0;
    run_layer(1, -1, 1, 12, "C");
    chk("C_flags2", pkt(2)[45:41], 5'b00010);
    chk("C_flags5", pkt(5)[45:41], 5'b00110);
    chk("C_flags11", pkt(11)[45:41], 5'b10111);

    // Mid-layer op_en pulse is ignored; a later pulse starts a fresh layer.
    cfg_w = 13'd3; cfg_h = 13'd1; cfg_s = 13'd0; cfg_sp = 8'd0;
    run_layer(1, 3, 0, 8, "D");
    chk("D_flags7", pkt(7)[45:41], 5'b10111);
    cfg_w = 13'd1; cfg_h = 13'd0;
    run_layer(1, -1, 0, 2, "D2");
    chk("D2_w0", pkt(0)[40:32], 0);
    chk("D2_flags1", pkt(1)[45:41], 5'b10111);

    // op_en held high across reset release counts as a rising edge.
    cfg_w = 13'd0; cfg_h = 13'd0; cfg_s = 13'd0; cfg_sp = 8'd0;
    rst = 1'b1; op_en = 1'b1; pd_ready = 1'b1;
    tick(); tick();
    chk("E33_rst_ready", rd_ready, 0);
    rst = 1'b0;
    tick();
    #1;
    chk("E33_armed_ready", rd_ready, 1);
    run_layer(0, -1, 0, 1, "E33");
    chk("E33_flags", pkt(0)[45:41], 5'b10111);

    // Width 600: the 9-bit width field wraps, the counter does not.
    cfg_w = 13'd600; cfg_h = 13'd0; cfg_s = 13'd0; cfg_sp = 8'd0;
    run_layer(1, -1, 0, 601, "W");
    chk("W_field511", pkt(511)[40:32], 511);
    chk("W_field512", pkt(512)[40:32], 0);
    chk("W_line512", pkt(512)[42], 0);
    chk("W_field600", pkt(600)[40:32], 88);
    chk("W_line600", pkt(600)[42], 1);
    chk("W_flags600", pkt(600)[45:41], 5'b10111);

    // Reset while draining discards the packet and never signals done.
    cfg_w = 13'd0; cfg_h = 13'd0; cfg_s = 13'd0; cfg_sp = 8'd0;
    op_en = 1'b1;
    tick();
    op_en = 1'b0;
    pd_ready = 1'b0; rd_valid = 1'b1; rd_pd = 32'hCAFE_F00D;
    tick();
    #1;
    chk("R_valid_drain", pd_valid, 1);
    chk("R_pd_drain", pd[31:0], 32'hCAFE_F00D);
    chk("R_ready_drain", rd_ready, 0);
    rst = 1'b1;
    tick();
    chk("R_valid_after", pd_valid, 0);
    chk("R_pd_after", pd, 46'h0);
    rst = 1'b0; pd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("R_no_done", done_pulse, 0);
      chk("R_idle_ready", rd_ready, 0);
      chk("R_idle_valid", pd_valid, 0);
    end
    rd_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_pdp_rdma_eg.md
NV_NVDLA_PDP_RDMA_EG -- requirements
Module: nv_nvdla_pdp_rdma_eg

Interface
REQ-001 Parameter: none; data width is fixed at 32 bits (4 bytes) and the packet is 46 bits.
REQ-002 nvdla_core_clk  input  1  Sole clock; all state updates on its rising edge.
REQ-003 nvdla_core_rst  input  1  Reset, synchronous and active-high.
REQ-004 reg2dp_op_en  input  1  Layer enable level; a rising edge arms one layer.
REQ-005 reg2dp_cube_in_width  input  13  Beats per line minus 1.
REQ-006 reg2dp_cube_in_height  input  13  Lines per surface minus 1.
REQ-007 reg2dp_surf_num  input  13  Surfaces per cube minus 1.
REQ-008 reg2dp_split_num  input  8  Splits per layer minus 1.
REQ-009 rd_data_pd  input  32  Raw read data beat from the RDMA return path.
REQ-010 rd_data_valid  input  1  rd_data_pd is valid.
REQ-011 rd_data_ready  output  1  The block accepts the raw beat.
REQ-012 pdp_rdma2dp_pd  output  46  Packet to the PDP core.
REQ-013 pdp_rdma2dp_valid  output  1  The packet is valid.
REQ-014 pdp_rdma2dp_ready  input  1  The core accepts the packet.
REQ-015 eg_done  output  1  One-cycle pulse when the last packet of the layer is accepted.

Function
REQ-016 Packet format:
- [31:0] data
- [40:32] width counter bits [8:0]
- [41] split_end: last split of the layer
- [42] line_end
- [43] surf_end
- [44] reserved, always 0
- [45] cube_end
REQ-017 Layer end is defined as a packet with [45]=1 and [41]=1; exactly one such packet SHALL be sent per layer.
REQ-018 FSM states:
- IDLE: rd_data_ready=0. Moves to RUN on the cycle after reg2dp_op_en rises (op_en_d1 edge detect), loading all counters to 0.
- RUN: moves to DRAIN when the layer-end beat is loaded into the output register.
- DRAIN: rd_data_ready=0. Moves to IDLE when the output register is accepted.
REQ-019 Counter order per load: w is innermost, then h, then surf, then split; each counter wraps to 0 when it equals its register value and the next-inner counter wraps.
REQ-020 Packet flags are computed from the counter values before the increment: line_end = (w==width), surf_end = line_end & (h==height), cube_end = surf_end & (surf==surf_num), split_end = cube_end & (split==split_num).
REQ-021 rd_data_ready = (state==RUN) & (~pdp_rdma2dp_valid | pdp_rdma2dp_ready).
REQ-022 load = rd_data_valid & rd_data_ready; on load the output register captures {flags, w[8:0], rd_data_pd} and pdp_rdma2dp_valid is set to 1.
REQ-023 Latency is exactly 1 cycle from the load to pdp_rdma2dp_valid; sustained throughput is 1 beat/cycle while ready is held high.
REQ-024 pdp_rdma2dp_valid clears on acceptance when no new load occurs in the same cycle; a simultaneous accept and load keeps valid at 1 and replaces the packet.
REQ-025 While pdp_rdma2dp_valid=1 and ready=0, pdp_rdma2dp_pd SHALL be held stable.
REQ-026 eg_done is asserted in the cycle of the DRAIN->IDLE transition only.
REQ-027 An op_en rising edge seen in RUN or DRAIN is ignored; no queuing. The op_en_d1 edge detector continues to track.
REQ-028 Register inputs are sampled only on the IDLE->RUN transition and held internally for the whole layer.
REQ-029 All-zero dimensions are legal: the first beat carries flags [45:41] = 5'b10111.
REQ-030 Width values above 511 SHALL wrap in the [40:32] field only; the internal counter is a full 13 bits.

Reset
REQ-031 Under nvdla_core_rst=1, the following take these values at the next clock edge:
- state = IDLE
- all counters = 0
- op_en_d1 = 0
- pdp_rdma2dp_valid = 0
- pdp_rdma2dp_pd = 0
- rd_data_ready = 0
- eg_done = 0
REQ-032 A reset during RUN or DRAIN discards any pending packet and the partial layer; a new op_en rising edge is required afterwards.
REQ-033 If reg2dp_op_en is held at 1 across reset release, it counts as a rising edge on the first post-reset cycle.

Verification
REQ-034 Dimensions width=3, height=1, surf=0, split=0, ready held 1 -> 8 packets; line_end on packets 4 and 8; packet 8 has [45:41] = 5'b10111; eg_done is pulsed one cycle after packet 8's valid cycle.
REQ-035 split_num=1, all other dimensions 0 -> packet 1 [45:41] = 5'b10110 and packet 2 = 5'b10111, giving exactly one layer end.
REQ-036 pdp_rdma2dp_ready toggling 1010..., input always valid -> no beats dropped or duplicated; pd is stable during stalls; data order matches input.
REQ-037 op_en pulsed again mid-layer -> ignored; a third pulse after eg_done starts a new layer with w=0.
REQ-038 Reset asserted in DRAIN with valid=1 -> valid=0 next cycle; eg_done is never pulsed; the block waits in IDLE.
REQ-039 width=600 -> packet index 512 shows [40:32] = 0 with line_end = 0; the final packet of the line shows 88 with line_end = 1.
